// File: rtl/fast_core_dbg_pkg.sv
// Shared types and helpers for the debug memory bridge: FSM state encoding,
// SFR-space address decode and the default stall-acknowledge timeout.
package fast_core_dbg_pkg;

   localparam int ACK_TIMEOUT_DEFAULT = 255;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      STALL_WAIT = 3'd1,
      RD_ISSUE   = 3'd2,
      RD_DRAIN   = 3'd3,
      WR         = 3'd4,
      DONE       = 3'd5
   } state_t;

   // SFR space is 0x0080..0x00FF: upper byte zero, bit 7 set.
   function automatic logic is_sfr_addr(input logic [15:0] addr);
      return (addr[15:8] == 8'h00) && addr[7];
   endfunction

endpackage

// File: rtl/fast_core_dbg_mem_bridge_if.sv
// Debugger-side command/data port of the bridge; master is the UART
// command engine, slave is the bridge.
interface fast_core_dbg_mem_bridge_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = 8
);
   logic                  dbg_req;
   logic                  dbg_rd1_wr0;
   logic [ADDR_WIDTH-1:0] dbg_addr;
   logic [LEN_WIDTH-1:0]  dbg_len;
   logic [7:0]            dbg_wdata;
   logic                  dbg_wdata_valid;
   logic                  dbg_wdata_ready;
   logic [7:0]            dbg_rdata;
   logic                  dbg_rdata_valid;
   logic                  dbg_busy;
   logic                  dbg_done;
   logic                  dbg_error;

   modport master (
      output dbg_req, dbg_rd1_wr0, dbg_addr, dbg_len, dbg_wdata, dbg_wdata_valid,
      input  dbg_wdata_ready, dbg_rdata, dbg_rdata_valid, dbg_busy, dbg_done, dbg_error
   );

   modport slave (
      input  dbg_req, dbg_rd1_wr0, dbg_addr, dbg_len, dbg_wdata, dbg_wdata_valid,
      output dbg_wdata_ready, dbg_rdata, dbg_rdata_valid, dbg_busy, dbg_done, dbg_error
   );
endinterface

// File: rtl/fast_core_dbg_burst_counter.sv
// Burst address incrementer (wraps modulo 2^ADDR_WIDTH) and remaining-byte
// down-counter where a loaded length of 0 means 2^LEN_WIDTH bytes.
module fast_core_dbg_burst_counter #(
   parameter int ADDR_WIDTH = 16,
   parameter int LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  load,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [LEN_WIDTH-1:0]  load_len,
   input  logic                  step,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic                  last
);
   localparam int RW = LEN_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [RW-1:0]         rem_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         addr_reg <= '0;
         rem_reg  <= '0;
      end else if (load) begin
         addr_reg <= load_addr;
         rem_reg  <= (load_len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, load_len};
      end else if (step) begin
         addr_reg <= addr_reg + ADDR_WIDTH'(1);
         rem_reg  <= rem_reg - RW'(1);
      end
   end

   assign addr = addr_reg;
   assign last = (rem_reg == RW'(1));

endmodule

// File: rtl/fast_core_dbg_mem_bridge.sv
// Debug memory bridge: passes core accesses through, or stalls the core and
// runs a debugger burst. Optional FAST_CORE_DBG_SFR_PROTECT_EN blocks SFR writes.
module fast_core_dbg_mem_bridge
   import fast_core_dbg_pkg::*;
#(
   parameter int ADDR_WIDTH  = 16,
   parameter int LEN_WIDTH   = 8,
   parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] core_read_addr,
   input  logic [ADDR_WIDTH-1:0] core_write_addr,
   input  logic [7:0]            core_data_in,
   input  logic                  core_we,
   output logic                  core_stall_req,
   input  logic                  core_stall_ack,
   output logic [ADDR_WIDTH-1:0] mem_read_addr,
   output logic [ADDR_WIDTH-1:0] mem_write_addr,
   output logic [7:0]            mem_data_in,
   output logic                  mem_we,
   input  logic [7:0]            mem_data_out,
   fast_core_dbg_mem_bridge_if.slave dbg
);
   localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

   state_t            state_reg, state_next;
   logic [TMO_W-1:0]  tmo_reg, tmo_next;
   logic              rd_reg;
   logic              rvalid_reg;
   logic              error_reg;
   logic              tmo_done_reg;

   logic                  cnt_load, cnt_step, cnt_last;
   logic [ADDR_WIDTH-1:0] cnt_addr;
   logic                  tmo_abort, sfr_block, wr_ready;

   fast_core_dbg_burst_counter #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LEN_WIDTH  (LEN_WIDTH)
   ) u_counter (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (cnt_load),
      .load_addr (dbg.dbg_addr),
      .load_len  (dbg.dbg_len),
      .step      (cnt_step),
      .addr      (cnt_addr),
      .last      (cnt_last)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         tmo_reg      <= '0;
         rd_reg       <= 1'b0;
         rvalid_reg   <= 1'b0;
         error_reg    <= 1'b0;
         tmo_done_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         tmo_reg      <= tmo_next;
         rvalid_reg   <= (state_reg == RD_ISSUE);
         tmo_done_reg <= tmo_abort;
         if (cnt_load) begin
            rd_reg    <= dbg.dbg_rd1_wr0;
            error_reg <= 1'b0;
         end else if (tmo_abort || sfr_block) begin
            error_reg <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      tmo_next       = tmo_reg;
      cnt_load       = 1'b0;
      cnt_step       = 1'b0;
      tmo_abort      = 1'b0;
      sfr_block      = 1'b0;
      wr_ready       = 1'b0;
      mem_read_addr  = core_read_addr;
      mem_write_addr = core_write_addr;
      mem_data_in    = core_data_in;
      mem_we         = core_we;

      // Outside IDLE/STALL_WAIT the bridge owns the data block ports.
      if (state_reg != IDLE && state_reg != STALL_WAIT) begin
         mem_read_addr  = cnt_addr;
         mem_write_addr = cnt_addr;
         mem_data_in    = 8'h00;
         mem_we         = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            tmo_next = '0;
            if (dbg.dbg_req) begin
               cnt_load   = 1'b1;
               state_next = STALL_WAIT;
            end
         end
         STALL_WAIT: begin
            if (core_stall_ack) begin
               state_next = rd_reg ? RD_ISSUE : WR;
            end else if (tmo_reg == TMO_W'(ACK_TIMEOUT - 1)) begin
               tmo_abort  = 1'b1;
               state_next = IDLE;
            end else begin
               tmo_next = tmo_reg + TMO_W'(1);
            end
         end
         RD_ISSUE: begin
            cnt_step = 1'b1;
            if (cnt_last) state_next = RD_DRAIN;
         end
         RD_DRAIN: state_next = DONE;
         WR: begin
            wr_ready    = 1'b1;
            mem_data_in = dbg.dbg_wdata;
            if (dbg.dbg_wdata_valid) begin
               cnt_step = 1'b1;
`ifdef FAST_CORE_DBG_SFR_PROTECT_EN
               if (is_sfr_addr(16'(cnt_addr))) sfr_block = 1'b1;
               else                            mem_we    = 1'b1;
`else
               mem_we = 1'b1;
`endif
               if (cnt_last) state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The timeout path returns straight to IDLE, so its done pulse is registered.
   assign core_stall_req      = (state_reg != IDLE) && (state_reg != DONE);
   assign dbg.dbg_busy        = (state_reg != IDLE);
   assign dbg.dbg_done        = (state_reg == DONE) || tmo_done_reg;
   assign dbg.dbg_error       = error_reg;
   assign dbg.dbg_wdata_ready = wr_ready;
   assign dbg.dbg_rdata_valid = rvalid_reg;
   assign dbg.dbg_rdata       = rvalid_reg ? mem_data_out : 8'h00;

endmodule

// File: tb/tb_fast_core_dbg_mem_bridge.sv
// Self-checking bench for fast_core_dbg_mem_bridge: pass-through vector table,
// then read/write/timeout/reset/SFR sequences checked through scoreboard queues.
module tb_fast_core_dbg_mem_bridge;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] core_read_addr, core_write_addr;
   logic [7:0]  core_data_in;
   logic        core_we, core_stall_ack;
   logic        core_stall_req;
   logic [15:0] mem_read_addr, mem_write_addr;
   logic [7:0]  mem_data_in;
   logic        mem_we;
   logic [7:0]  mem_data_out;

   always #5 clk = ~clk;

   fast_core_dbg_mem_bridge_if #(.ADDR_WIDTH(16), .LEN_WIDTH(8)) dbg ();

   fast_core_dbg_mem_bridge #(.ADDR_WIDTH(16), .LEN_WIDTH(8), .ACK_TIMEOUT(255)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .core_read_addr  (core_read_addr),
      .core_write_addr (core_write_addr),
      .core_data_in    (core_data_in),
      .core_we         (core_we),
      .core_stall_req  (core_stall_req),
      .core_stall_ack  (core_stall_ack),
      .mem_read_addr   (mem_read_addr),
      .mem_write_addr  (mem_write_addr),
      .mem_data_in     (mem_data_in),
      .mem_we          (mem_we),
      .mem_data_out    (mem_data_out),
      .dbg             (dbg)
   );

   typedef struct {
      logic [15:0] in_ra, in_wa;
      logic [7:0]  in_d;
      logic        in_we;
      logic [15:0] exp_ra, exp_wa;
      logic [7:0]  exp_d;
      logic        exp_we;
   } pt_vec_t;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  d;
   } wr_t;

   logic [7:0]  ram [0:65535];
   wr_t         wr_q [$];
   logic [7:0]  rd_q [$];
   int          checks, failures;
   int          rv_cnt, we_cnt, done_cnt, stall_cnt;
   logic        s_we, s_ready, s_busy;
   logic [15:0] s_ra, s_wa;
   logic [7:0]  s_wd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // One clock: sample mid-low-phase, run scoreboards, then advance the RAM model.
   task automatic cycle();
      wr_t         w;
      logic [7:0]  r;
      #2;
      s_we = mem_we; s_wa = mem_write_addr; s_wd = mem_data_in; s_ra = mem_read_addr;
      s_ready = dbg.dbg_wdata_ready; s_busy = dbg.dbg_busy;
      if (dbg.dbg_rdata_valid) begin
         rv_cnt++;
         if (rd_q.size() == 0) check("rd_unexpected", 32'(dbg.dbg_rdata), 32'hFFFF_FFFF);
         else begin
            r = rd_q.pop_front();
            check("rdata", 32'(dbg.dbg_rdata), 32'(r));
         end
      end
      if (s_we && s_busy) begin
         we_cnt++;
         if (wr_q.size() == 0) check("wr_unexpected", 32'(s_wa), 32'hFFFF_FFFF);
         else begin
            w = wr_q.pop_front();
            check("wr_addr", 32'(s_wa), 32'(w.a));
            check("wr_data", 32'(s_wd), 32'(w.d));
         end
      end
      if (dbg.dbg_done) done_cnt++;
      if (core_stall_req) stall_cnt++;
      @(posedge clk);
      if (s_we) ram[s_wa] = s_wd;
      mem_data_out = ram[s_ra];
      @(negedge clk);
   endtask

   task automatic run_until_done(input int budget, input string name);
      int start;
      start = done_cnt;
      for (int i = 0; i < budget && done_cnt == start; i++) cycle();
      check(name, done_cnt - start, 1);
   endtask

   task automatic start_burst(input logic rd, input logic [15:0] addr, input logic [7:0] len);
      dbg.dbg_rd1_wr0 = rd; dbg.dbg_addr = addr; dbg.dbg_len = len; dbg.dbg_req = 1'b1;
      cycle();
      dbg.dbg_req = 1'b0;
   endtask

   pt_vec_t     vec [4];
   logic [7:0]  wb [3];
   int          idx, gap, rv0, we0, st0;

   initial begin
      checks = 0; failures = 0; rv_cnt = 0; we_cnt = 0; done_cnt = 0; stall_cnt = 0;
      for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
      reset_n = 1'b0; core_read_addr = '0; core_write_addr = '0; core_data_in = '0;
      core_we = 1'b0; core_stall_ack = 1'b0; mem_data_out = '0;
      dbg.dbg_req = 1'b0; dbg.dbg_rd1_wr0 = 1'b0; dbg.dbg_addr = '0; dbg.dbg_len = '0;
      dbg.dbg_wdata = '0; dbg.dbg_wdata_valid = 1'b0;
      @(negedge clk);
      cycle(); cycle();
      check("rst_busy",   32'(dbg.dbg_busy), 0);
      check("rst_stall",  32'(core_stall_req), 0);
      check("rst_ready",  32'(dbg.dbg_wdata_ready), 0);
      check("rst_rvalid", 32'(dbg.dbg_rdata_valid), 0);
      check("rst_done",   32'(dbg.dbg_done), 0);
      check("rst_error",  32'(dbg.dbg_error), 0);
      check("rst_rdata",  32'(dbg.dbg_rdata), 0);
      reset_n = 1'b1;
      $display("txn reset released");

      vec[0] = '{16'h0010, 16'h0030, 8'h5A, 1'b1, 16'h0010, 16'h0030, 8'h5A, 1'b1};
      vec[1] = '{16'hFFFF, 16'h1234, 8'hA5, 1'b0, 16'hFFFF, 16'h1234, 8'hA5, 1'b0};
      vec[2] = '{16'h00E0, 16'h0085, 8'hFF, 1'b1, 16'h00E0, 16'h0085, 8'hFF, 1'b1};
      vec[3] = '{16'h8000, 16'hFFFE, 8'h00, 1'b1, 16'h8000, 16'hFFFE, 8'h00, 1'b1};
      for (int i = 0; i < 4; i++) begin
         core_read_addr = vec[i].in_ra; core_write_addr = vec[i].in_wa;
         core_data_in = vec[i].in_d; core_we = vec[i].in_we;
         cycle();
         check("pt_ra",   32'(s_ra), 32'(vec[i].exp_ra));
         check("pt_wa",   32'(s_wa), 32'(vec[i].exp_wa));
         check("pt_d",    32'(s_wd), 32'(vec[i].exp_d));
         check("pt_we",   32'(s_we), 32'(vec[i].exp_we));
         check("pt_busy", 32'(s_busy), 0);
         $display("txn passthrough wa=0x%04h we=%0d", vec[i].in_wa, vec[i].in_we);
      end
      core_we = 1'b0; core_read_addr = '0; core_write_addr = '0;

      // Burst read with a 3-cycle ack delay and an ignored request while busy.
      ram[16'h1000] = 8'h11; ram[16'h1001] = 8'h22; ram[16'h1002] = 8'h33; ram[16'h1003] = 8'h44;
      rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33); rd_q.push_back(8'h44);
      rv0 = rv_cnt;
      start_burst(1'b1, 16'h1000, 8'd4);
      cycle();
      dbg.dbg_req = 1'b1; dbg.dbg_addr = 16'h2000; dbg.dbg_rd1_wr0 = 1'b0;
      cycle();
      dbg.dbg_req = 1'b0;
      cycle();
      check("rd_wait_stall", 32'(core_stall_req), 1);
      check("rd_wait_busy",  32'(dbg.dbg_busy), 1);
      core_stall_ack = 1'b1;
      run_until_done(20, "rd_done");
      check("rd_count",    rv_cnt - rv0, 4);
      check("rd_q_empty",  rd_q.size(), 0);
      check("rd_stall_rel", 32'(core_stall_req), 0);
      check("rd_busy_rel", 32'(dbg.dbg_busy), 0);
      core_stall_ack = 1'b0;
      $display("txn burst read addr=0x1000 len=4");

      // Burst write with a gap, wrapping past 0xFFFF.
      wb[0] = 8'hAA; wb[1] = 8'hBB; wb[2] = 8'hCC;
      wr_q.push_back('{16'hFFFE, 8'hAA}); wr_q.push_back('{16'hFFFF, 8'hBB});
      wr_q.push_back('{16'h0000, 8'hCC});
      we0 = we_cnt;
      start_burst(1'b0, 16'hFFFE, 8'd3);
      core_stall_ack = 1'b1;
      idx = 0; gap = 0;
      for (int i = 0; i < 40 && idx < 3; i++) begin
         if (gap > 0) begin
            dbg.dbg_wdata_valid = 1'b0;
            cycle();
            gap--;
         end else begin
            dbg.dbg_wdata_valid = 1'b1; dbg.dbg_wdata = wb[idx];
            cycle();
            if (s_ready) begin
               idx++;
               if (idx == 1) gap = 2;
            end
         end
      end
      dbg.dbg_wdata_valid = 1'b0;
      check("wr_consumed", idx, 3);
      run_until_done(10, "wr_done");
      check("wr_count",   we_cnt - we0, 3);
      check("wr_q_empty", wr_q.size(), 0);
      check("wr_error",   32'(dbg.dbg_error), 0);
      core_stall_ack = 1'b0;
      $display("txn burst write addr=0xFFFE len=3");

      // Ack timeout.
      we0 = we_cnt;
      start_burst(1'b0, 16'h0100, 8'd1);
      st0 = stall_cnt;
      run_until_done(300, "tmo_done");
      check("tmo_stall_cycles", stall_cnt - st0, 255);
      check("tmo_error",  32'(dbg.dbg_error), 1);
      check("tmo_no_we",  we_cnt - we0, 0);
      check("tmo_stall",  32'(core_stall_req), 0);
      $display("txn timeout");

      // Reset in the middle of a 256-byte write.
      for (int i = 0; i < 10; i++) wr_q.push_back('{16'h4000 + 16'(i), 8'(i)});
      we0 = we_cnt;
      start_burst(1'b0, 16'h4000, 8'd0);
      check("err_cleared", 32'(dbg.dbg_error), 0);
      core_stall_ack = 1'b1;
      idx = 0;
      for (int i = 0; i < 30 && idx < 10; i++) begin
         dbg.dbg_wdata_valid = 1'b1; dbg.dbg_wdata = 8'(idx);
         cycle();
         if (s_ready) idx++;
      end
      dbg.dbg_wdata_valid = 1'b0;
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      check("mr_stall",  32'(core_stall_req), 0);
      check("mr_busy",   32'(dbg.dbg_busy), 0);
      check("mr_ready",  32'(dbg.dbg_wdata_ready), 0);
      check("mr_done",   32'(dbg.dbg_done), 0);
      check("mr_rvalid", 32'(dbg.dbg_rdata_valid), 0);
      core_stall_ack = 1'b0;
      dbg.dbg_wdata_valid = 1'b1;
      cycle(); cycle(); cycle();
      dbg.dbg_wdata_valid = 1'b0;
      check("mr_we_count", we_cnt - we0, 10);
      check("mr_q_empty",  wr_q.size(), 0);
      $display("txn reset mid-burst after %0d bytes", idx);

      // Single write into SFR space.
      we0 = we_cnt;
`ifndef FAST_CORE_DBG_SFR_PROTECT_EN
      wr_q.push_back('{16'h00E0, 8'h77});
`endif
      start_burst(1'b0, 16'h00E0, 8'd1);
      core_stall_ack = 1'b1;
      dbg.dbg_wdata_valid = 1'b1; dbg.dbg_wdata = 8'h77;
      run_until_done(10, "sfr_done");
      dbg.dbg_wdata_valid = 1'b0;
      core_stall_ack = 1'b0;
`ifdef FAST_CORE_DBG_SFR_PROTECT_EN
      check("sfr_we_count", we_cnt - we0, 0);
      check("sfr_error",    32'(dbg.dbg_error), 1);
`else
      check("sfr_we_count", we_cnt - we0, 1);
      check("sfr_error",    32'(dbg.dbg_error), 0);
      check("sfr_q_empty",  wr_q.size(), 0);
`endif
      $display("txn write addr=0x00E0 len=1");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fast_core_dbg_mem_bridge.md
Name: fast_core_dbg_mem_bridge

Overview:
- Debug-side memory access bridge. Sits directly upstream of the on-chip data block, between the core's data-port signals and the RAM/SFR read/write ports.
- Normally passes core requests straight through.
- On a debug request it stalls the core, takes the ports, and runs a burst read or burst write with address auto-increment.
- It then returns the ports to the core.
- Used by the on-chip debugger (UART command engine) to peek/poke IRAM, SFR and XRAM.

Parameters:
- ADDR_WIDTH, 16, width of read/write address.
- LEN_WIDTH, 8, burst length field width; value 0 encodes 2^LEN_WIDTH bytes.
- ACK_TIMEOUT, 255, max cycles to wait for core_stall_ack before aborting.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- core_read_addr  in  ADDR_WIDTH  core read address
- core_write_addr  in  ADDR_WIDTH  core write address
- core_data_in  in  8  core write data
- core_we  in  1  core write enable
- core_stall_req  out  1  request core to freeze
- core_stall_ack  in  1  core frozen, no access in flight
- mem_read_addr  out  ADDR_WIDTH  to data block
- mem_write_addr  out  ADDR_WIDTH  to data block
- mem_data_in  out  8  to data block
- mem_we  out  1  to data block
- mem_data_out  in  8  read data, valid 1 cycle after mem_read_addr
- dbg_req  in  1  start pulse, sampled in IDLE only
- dbg_rd1_wr0  in  1  1 = burst read, 0 = burst write
- dbg_addr  in  ADDR_WIDTH  start address
- dbg_len  in  LEN_WIDTH  byte count (0 = max)
- dbg_wdata  in  8  write byte
- dbg_wdata_valid  in  1  write byte present
- dbg_wdata_ready  out  1  bridge consumes byte this cycle
- dbg_rdata  out  8  read byte
- dbg_rdata_valid  out  1  dbg_rdata valid, 1-cycle pulse per byte
- dbg_busy  out  1  not IDLE
- dbg_done  out  1  1-cycle pulse at burst end
- dbg_error  out  1  sticky abort flag; cleared by next accepted dbg_req

Behaviour:
- Reset (reset_n low at clk edge): state IDLE; core_stall_req, dbg_wdata_ready, dbg_rdata_valid, dbg_busy, dbg_done, dbg_error = 0; dbg_rdata = 0; counters and registered address = 0.
- Reset mid-burst: abandon immediately; no further mem_we; core released next cycle.
- Mux: in IDLE and STALL_WAIT, mem_* = core_* combinationally (zero latency). In all other states, mem_* are driven by the bridge and core_we is ignored.
- IDLE: on dbg_req, latch addr/len/dir, clear dbg_error, assert core_stall_req, go to STALL_WAIT.
- STALL_WAIT:
  - Timeout counter runs from 0.
  - core_stall_ack=1: go to RD_ISSUE or WR.
  - Counter reaches ACK_TIMEOUT: set dbg_error, drop stall, go to IDLE, pulse dbg_done.
- RD_ISSUE:
  - Each cycle: mem_read_addr = cur_addr, cur_addr += 1 (wraps modulo 2^ADDR_WIDTH, 0xFFFF -> 0x0000), remaining -= 1.
  - One cycle later dbg_rdata = mem_data_out with dbg_rdata_valid=1.
  - After the last issue go to RD_DRAIN.
  - Throughput 1 byte/cycle; no read backpressure.
- RD_DRAIN: one cycle to present the final byte, then DONE.
- WR:
  - dbg_wdata_ready=1 while remaining>0.
  - On valid&ready: mem_write_addr = cur_addr, mem_data_in = dbg_wdata, mem_we=1 the same cycle; increment/wrap address; decrement remaining.
  - Idle cycles (valid=0) are allowed with no timeout.
  - At remaining=0 go to DONE.
- DONE:
  - Pulse dbg_done.
  - Deassert core_stall_req; state returns to IDLE the same edge.
  - dbg_busy drops the next cycle.
- Bridge reads never hit a write in the same cycle, so the data block's read-after-write bypass is not exercised by the bridge.
- Length 0: 2^LEN_WIDTH bytes (256 at default).
- dbg_req while busy: ignored.
- core_stall_ack dropping mid-burst: ignored; the bridge owns the ports until DONE.

Optional Feature:
- FAST_CORE_DBG_SFR_PROTECT_EN defined: a bridge write whose address has bits [15:8]=0 and bit 7=1 (SFR space) is consumed but gated (mem_we=0), and dbg_error is set. The burst still completes.
- Not defined: all addresses are writable.

Decomposition:
- Shared package fast_core_dbg_pkg: state enum (IDLE, STALL_WAIT, RD_ISSUE, RD_DRAIN, WR, DONE), SFR-space decode function, ACK_TIMEOUT default constant.
- One natural sub-module: fast_core_dbg_burst_counter (address incrementer with wrap, plus remaining-byte down-counter with 0 = max encoding).

Test Plan:
- Pass-through: IDLE, core_write_addr=0x0030, core_we=1, core_data_in=0x5A -> mem_we=1, mem_write_addr=0x0030 the same cycle; dbg_busy=0.
- Burst read: preload XRAM 0x1000..0x1003 = 11,22,33,44; dbg_req rd, addr=0x1000, len=4, ack after 3 cycles -> four consecutive dbg_rdata_valid with 11,22,33,44; dbg_done; stall released.
- Burst write with gaps and wrap: addr=0xFFFE, len=3, wdata AA,(gap 2 cycles),BB,CC -> writes 0xFFFE=AA, 0xFFFF=BB, 0x0000=CC; exactly 3 mem_we pulses.
- Timeout: core_stall_ack held 0 -> after 255 cycles dbg_error=1, dbg_done pulse, no mem_we, core_stall_req=0.
- Reset mid-burst: len=0 write, reset_n low after 10 bytes -> all outputs at reset values the next cycle; no further writes.
- With FAST_CORE_DBG_SFR_PROTECT_EN: write addr=0x00E0, len=1 -> mem_we stays 0, dbg_error=1, dbg_done pulses.
